// File: rtl/ntt_coeff_serializer.sv
// Captures a 16-wide NTT result, folds each coefficient once into [0, Q) and streams the
// coefficients out over a valid/ready port, one per transfer, with sticky error flags.
module ntt_coeff_serializer #(
  parameter int unsigned Q = 3329,
  parameter int unsigned N = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cap,
  input  logic [15:0] ntt_0,
  input  logic [15:0] ntt_1,
  input  logic [15:0] ntt_2,
  input  logic [15:0] ntt_3,
  input  logic [15:0] ntt_4,
  input  logic [15:0] ntt_5,
  input  logic [15:0] ntt_6,
  input  logic [15:0] ntt_7,
  input  logic [15:0] ntt_8,
  input  logic [15:0] ntt_9,
  input  logic [15:0] ntt_10,
  input  logic [15:0] ntt_11,
  input  logic [15:0] ntt_12,
  input  logic [15:0] ntt_13,
  input  logic [15:0] ntt_14,
  input  logic [15:0] ntt_15,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_idx,
  output logic        out_last,
  output logic        busy,
  output logic        done,
  output logic        ovf_err,
  output logic        range_err
);

  localparam logic [0:0]  StIdle   = 1'b0;
  localparam logic [0:0]  StStream = 1'b1;
  localparam logic [15:0] QW       = 16'(Q);
  localparam logic [16:0] Q2       = 17'(2 * Q);
  localparam logic [3:0]  LastIdx  = 4'(N - 1);

  logic [0:0]  state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic        done_q, ovf_q, range_q;
  logic [15:0] coef_q [N];
  logic [15:0] coeff [N];
  logic [15:0] reduced [N];
  logic        any_big;
  logic        stream, xfer, last_xfer, accept, drop;

  assign coeff[0]  = ntt_0;
  assign coeff[1]  = ntt_1;
  assign coeff[2]  = ntt_2;
  assign coeff[3]  = ntt_3;
  assign coeff[4]  = ntt_4;
  assign coeff[5]  = ntt_5;
  assign coeff[6]  = ntt_6;
  assign coeff[7]  = ntt_7;
  assign coeff[8]  = ntt_8;
  assign coeff[9]  = ntt_9;
  assign coeff[10] = ntt_10;
  assign coeff[11] = ntt_11;
  assign coeff[12] = ntt_12;
  assign coeff[13] = ntt_13;
  assign coeff[14] = ntt_14;
  assign coeff[15] = ntt_15;

  // Single conditional subtract; inputs at or above 2Q are flagged but stored unclamped.
  always_comb begin
    any_big = 1'b0;
    for (int k = 0; k < N; k++) begin
      reduced[k] = (coeff[k] >= QW) ? coeff[k] - QW : coeff[k];
      if ({1'b0, coeff[k]} >= Q2) any_big = 1'b1;
    end
  end

  always_comb begin
    stream    = (state_q == StStream);
    xfer      = stream & out_ready;
    last_xfer = xfer & (idx_q == LastIdx);
    // A capture landing on the final transfer reloads back-to-back instead of overflowing.
    accept    = cap & (~stream | last_xfer);
    drop      = cap & stream & ~last_xfer;

    state_d = state_q;
    if (accept)         state_d = StStream;
    else if (last_xfer) state_d = StIdle;

    idx_d = idx_q;
    if (accept)    idx_d = 4'd0;
    else if (xfer) idx_d = idx_q + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= 4'd0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      range_q <= 1'b0;
      for (int k = 0; k < N; k++) coef_q[k] <= 16'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      done_q  <= last_xfer;
      ovf_q   <= ovf_q | drop;
      range_q <= range_q | (accept & any_big);
      if (accept) begin
        for (int k = 0; k < N; k++) coef_q[k] <= reduced[k];
      end
    end
  end

  always_comb begin
    out_valid = stream;
    out_data  = stream ? coef_q[idx_q] : 16'd0;
    out_idx   = stream ? idx_q : 4'd0;
    out_last  = stream & (idx_q == LastIdx);
    busy      = stream;
    done      = done_q;
    ovf_err   = ovf_q;
    range_err = range_q;
  end

endmodule

// File: tb/tb_ntt_coeff_serializer.sv
// Scoreboard bench for ntt_coeff_serializer: stimulus pushes expected coefficients,
// a negedge monitor pops and compares on every transfer and checks backpressure holds.
module tb_ntt_coeff_serializer;

  logic        clk = 1'b0;
  logic        rst, cap, out_ready;
  logic [15:0] ntt [16];
  logic [15:0] out_data;
  logic        out_valid, out_last, busy, done, ovf_err, range_err;
  logic [3:0]  out_idx;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [15:0] d;
    logic [3:0]  i;
    logic        l;
  } exp_t;
  exp_t sb [$];

  bit          pattern_mode = 1'b0;
  int          rdy_cnt = 0;
  bit          exp_done = 1'b0;
  bit          hold_pend = 1'b0;
  logic [15:0] hold_d;
  logic [3:0]  hold_i;

  ntt_coeff_serializer #(.Q(3329), .N(16)) dut (
    .clk(clk), .rst(rst), .cap(cap),
    .ntt_0(ntt[0]), .ntt_1(ntt[1]), .ntt_2(ntt[2]), .ntt_3(ntt[3]),
    .ntt_4(ntt[4]), .ntt_5(ntt[5]), .ntt_6(ntt[6]), .ntt_7(ntt[7]),
    .ntt_8(ntt[8]), .ntt_9(ntt[9]), .ntt_10(ntt[10]), .ntt_11(ntt[11]),
    .ntt_12(ntt[12]), .ntt_13(ntt[13]), .ntt_14(ntt[14]), .ntt_15(ntt[15]),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_idx(out_idx), .out_last(out_last), .busy(busy), .done(done),
    .ovf_err(ovf_err), .range_err(range_err)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ref_red(input logic [15:0] c);
    return (c >= 16'd3329) ? c - 16'd3329 : c;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_data"},  32'(out_data),  32'd0);
    chk({tag, "_idx"},   32'(out_idx),   32'd0);
    chk({tag, "_last"},  32'(out_last),  32'd0);
    chk({tag, "_busy"},  32'(busy),      32'd0);
    chk({tag, "_done"},  32'(done),      32'd0);
    chk({tag, "_ovf"},   32'(ovf_err),   32'd0);
    chk({tag, "_range"}, 32'(range_err), 32'd0);
  endtask

  // Called at posedge+1; leaves cap low at the next posedge+1.
  task automatic issue_cap(input bit accept);
    exp_t e;
    cap = 1'b1;
    if (accept) begin
      for (int k = 0; k < 16; k++) begin
        e.d = ref_red(ntt[k]);
        e.i = 4'(k);
        e.l = (k == 15);
        sb.push_back(e);
      end
    end
    @(posedge clk); #1;
    cap = 1'b0;
    if (accept) begin
      chk("first_valid", 32'(out_valid), 32'd1);
      chk("first_idx",   32'(out_idx),   32'd0);
    end
  endtask

  task automatic wait_drain();
    for (int c = 0; c < 300; c++) begin
      if (sb.size() == 0 && !out_valid) return;
      @(posedge clk); #1;
    end
    n_cmp++;
    n_fail++;
    $display("FAIL drain_timeout: %0d entries left, expected 0", sb.size());
  endtask

  task automatic wait_idx(input logic [3:0] t);
    for (int c = 0; c < 100; c++) begin
      if (out_valid && out_idx == t) return;
      @(posedge clk); #1;
    end
    n_cmp++;
    n_fail++;
    $display("FAIL wait_idx: got idx %0d, expected %0d", out_idx, t);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (pattern_mode) begin
        out_ready = (rdy_cnt % 3 == 0);
        rdy_cnt++;
      end else begin
        out_ready = 1'b1;
      end
    end
  end

  // Monitor: sampled on the falling edge, mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      hold_pend = 1'b0;
      exp_done  = 1'b0;
    end else begin
      if (exp_done) begin
        chk("done_pulse", 32'(done), 32'd1);
        exp_done = 1'b0;
      end
      if (hold_pend) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_data",  32'(out_data),  32'(hold_d));
        chk("hold_idx",   32'(out_idx),   32'(hold_i));
      end
      hold_pend = 1'b0;
      if (out_valid && !out_ready) begin
        hold_pend = 1'b1;
        hold_d    = out_data;
        hold_i    = out_idx;
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL extra_transfer: got idx %0d data %0d, expected none", out_idx, out_data);
        end else begin
          e = sb.pop_front();
          chk("stream_data", 32'(out_data), 32'(e.d));
          chk("stream_idx",  32'(out_idx),  32'(e.i));
          chk("stream_last", 32'(out_last), 32'(e.l));
          if (e.l) exp_done = 1'b1;
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    cap = 1'b0;
    for (int k = 0; k < 16; k++) ntt[k] = 16'd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_idle("reset");

    // Basic streaming at full throughput.
    for (int k = 0; k < 16; k++) ntt[k] = 16'(k * 100);
    issue_cap(1'b1);
    repeat (16) begin @(posedge clk); #1; end
    chk("basic_end_valid", 32'(out_valid), 32'd0);
    chk("basic_end_done",  32'(done),      32'd1);
    chk("basic_end_busy",  32'(busy),      32'd0);
    @(posedge clk); #1;
    chk("basic_done_once", 32'(done), 32'd0);
    chk("basic_range",     32'(range_err), 32'd0);

    // Reduction boundaries: 3329 -> 0, 4000 -> 671, 3328 unchanged.
    for (int k = 0; k < 16; k++) ntt[k] = 16'(k);
    ntt[3] = 16'd3329;
    ntt[4] = 16'd4000;
    ntt[5] = 16'd3328;
    issue_cap(1'b1);
    wait_drain();
    chk("reduce_range", 32'(range_err), 32'd0);

    // Range error (7000 -> 3671) with ready pattern 1,0,0.
    for (int k = 0; k < 16; k++) ntt[k] = 16'(k * 10);
    ntt[7] = 16'd7000;
    rdy_cnt = 0;
    pattern_mode = 1'b1;
    issue_cap(1'b1);
    chk("range_set", 32'(range_err), 32'd1);
    wait_drain();
    pattern_mode = 1'b0;
    chk("range_sticky", 32'(range_err), 32'd1);
    do_reset();
    chk_idle("reset2");

    // Overflow: capture while streaming index 5 is dropped.
    for (int k = 0; k < 16; k++) ntt[k] = 16'(k * 7 + 1);
    issue_cap(1'b1);
    wait_idx(4'd5);
    chk("ovf_before", 32'(ovf_err), 32'd0);
    for (int k = 0; k < 16; k++) ntt[k] = 16'(1000 + k);
    issue_cap(1'b0);
    chk("ovf_set", 32'(ovf_err), 32'd1);
    wait_drain();
    chk("ovf_sticky", 32'(ovf_err), 32'd1);
    do_reset();

    // Back-to-back: capture coincident with the index-15 transfer.
    for (int k = 0; k < 16; k++) ntt[k] = 16'(200 + k);
    issue_cap(1'b1);
    wait_idx(4'd15);
    for (int k = 0; k < 16; k++) ntt[k] = 16'(3000 + k * 50);
    issue_cap(1'b1);
    chk("b2b_done", 32'(done),    32'd1);
    chk("b2b_ovf",  32'(ovf_err), 32'd0);
    wait_drain();
    chk("b2b_ovf_end", 32'(ovf_err), 32'd0);

    // Mid-stream reset at index 8, then a clean stream.
    for (int k = 0; k < 16; k++) ntt[k] = 16'(k * 3);
    issue_cap(1'b1);
    wait_idx(4'd8);
    do_reset();
    chk_idle("midrst");
    for (int k = 0; k < 16; k++) ntt[k] = 16'(500 + k);
    issue_cap(1'b1);
    wait_drain();

    // Reset wins over a simultaneous capture.
    rst = 1'b1;
    cap = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    cap = 1'b0;
    chk("rstcap_valid", 32'(out_valid), 32'd0);
    chk("rstcap_busy",  32'(busy),      32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rstcap_still_idle", 32'(out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ntt_coeff_serializer.md
NTT_COEFF_SERIALIZER -- requirements
Module: ntt_coeff_serializer

Interface
REQ-001 SHALL have parameter Q, default 3329, the Kyber modulus used for the final conditional reduction.
REQ-002 SHALL have parameter N, default 16, the number of parallel coefficients per capture; the index width is log2(N) = 4.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port cap, input, 1, a one-cycle pulse marking the ntt_* inputs as a valid NTT result.
REQ-006 SHALL have ports ntt_0 .. ntt_15, input, 16 each, the parallel butterfly-array coefficients.
REQ-007 SHALL have port out_data, output, 16, the serialized reduced coefficient.
REQ-008 SHALL have port out_valid, output, 1, which is high when out_data holds a coefficient.
REQ-009 SHALL have port out_ready, input, 1, the downstream accept signal.
REQ-010 SHALL have port out_idx, output, 4, the index of the coefficient on out_data.
REQ-011 SHALL have port out_last, output, 1, which is high with out_valid when out_idx = 15.
REQ-012 SHALL have port busy, output, 1, which is high while in the STREAM state.
REQ-013 SHALL have port done, output, 1, a one-cycle pulse after the transfer of coefficient 15.
REQ-014 SHALL have port ovf_err, output, 1, a sticky flag set when a capture is dropped.
REQ-015 SHALL have port range_err, output, 1, a sticky flag set when a captured coefficient is ≥ 2Q.

Function
REQ-016 SHALL implement a two-state FSM with states IDLE and STREAM.
REQ-017 SHALL, when cap=1 is seen in IDLE, register all 16 coefficients into an internal buffer in that cycle, with each coefficient reduced as follows.
- c ≥ Q: store c − Q.
- c < Q: store c unchanged.
- Reduction happens before storage.
REQ-018 SHALL set range_err=1 on the cycle after a capture in which any accepted ntt_k ≥ 2·Q (6658); the stored value is still c − Q, unclamped.
REQ-019 SHALL enter STREAM on the cycle after the capture, with out_valid=1, out_idx=0 and out_data=buffer[0]; latency from cap to first valid is 1 cycle.
REQ-020 SHALL hold out_data, out_idx and out_valid stable while out_valid=1 and out_ready=0.
REQ-021 SHALL define a transfer as out_valid & out_ready at a rising edge; on each transfer, out_idx increments and out_data shows buffer[out_idx+1] on the next cycle.
REQ-022 SHALL, on the transfer with out_idx=15, return to IDLE with out_valid=0 and pulse done=1 for exactly the following cycle.
REQ-023 SHALL, when cap=1 arrives in STREAM other than on the final transfer cycle, ignore it, leave the buffer unchanged and set ovf_err=1 on the next cycle.
REQ-024 SHALL, when cap=1 arrives in the same cycle as the transfer of index 15, accept it as a back-to-back load.
- The buffer is reloaded.
- The FSM stays in STREAM with out_idx=0 next cycle.
- done still pulses.
- ovf_err is not set.
REQ-025 SHALL leave ovf_err and range_err set until rst; they are not cleared by new captures.
REQ-026 SHALL drive out_data=0 and out_idx=0 whenever out_valid=0.
REQ-027 SHALL never present more than 16 transfers per accepted capture, and the out_idx wrap from 15 to 0 occurs only via REQ-024.

Reset
REQ-028 SHALL, on rst=1 at a rising edge, set the following regardless of state, including mid-stream:
- FSM to IDLE.
- out_valid=0, out_data=0, out_idx=0, out_last=0.
- busy=0, done=0, ovf_err=0, range_err=0.
- The buffer is cleared to 0.
REQ-029 SHALL give rst priority over a cap in the same cycle; that capture is discarded.

Verification
REQ-030 SHALL cover basic streaming: ntt_k=k·100 (k=0..15), cap pulse, out_ready=1 held -> out_data sequence 0,100,...,1500 on 16 consecutive cycles starting 1 cycle after cap, out_last at 1500, done pulse the following cycle.
REQ-031 SHALL cover reduction: ntt_3=3329, ntt_4=4000, ntt_5=3328 -> streamed values 0, 671, 3328; range_err stays 0.
REQ-032 SHALL cover range error and backpressure: ntt_7=7000 with out_ready toggling 1,0,0,1,... -> index 7 outputs 3671, range_err=1, and outputs hold steady on every ready=0 cycle.
REQ-033 SHALL cover overflow: a second cap at out_idx=5 -> stream continues with the first data set, ovf_err=1 next cycle.
REQ-034 SHALL cover back-to-back: a second cap coincident with the index-15 transfer -> done pulse and a new stream at idx 0 the next cycle, ovf_err=0.
REQ-035 SHALL cover mid-stream reset: rst at out_idx=8 -> next cycle all outputs 0 and FSM IDLE; a subsequent cap streams normally from idx 0.
